// File: rtl/cmp_pkg.sv
// Shared definitions for the compare-class issue unit: MIPS opcode/funct
// constants, comparator op codes, operand-B selection and FSM states.
package cmp_pkg;

  localparam logic [5:0] OPC_SPECIAL  = 6'h00;
  localparam logic [5:0] OPC_SLTI     = 6'h0A;
  localparam logic [5:0] OPC_SLTIU    = 6'h0B;
  localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;
  localparam logic [5:0] FN_CLZ  = 6'h20;
  localparam logic [5:0] FN_CLO  = 6'h21;

  typedef enum logic [2:0] {
    OP_SLT   = 3'd0,
    OP_SLTU  = 3'd1,
    OP_SLTI  = 3'd2,
    OP_SLTIU = 3'd3,
    OP_CLO   = 3'd4,
    OP_CLZ   = 3'd5
  } cmp_op_e;

  typedef enum logic [1:0] {
    BSEL_RT   = 2'd0,
    BSEL_IMM  = 2'd1,
    BSEL_ZERO = 2'd2
  } bsel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // The comparator is not trusted when every bit of rs matches the counted value.
  function automatic logic is_full_width(input cmp_op_e op, input logic [31:0] a);
    return ((op == OP_CLO) && (a == 32'hFFFF_FFFF)) ||
           ((op == OP_CLZ) && (a == 32'h0000_0000));
  endfunction

endpackage

// File: rtl/cmp_issue_decode.sv
// Combinational decode of a compare-class instruction into legality,
// comparator op, operand-B source and destination register.
module cmp_issue_decode
  import cmp_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rt,
  output logic             legal,
  output cmp_op_e          op,
  output bsel_e            bsel,
  output logic [REG_W-1:0] dest
);

  always_comb begin
    legal = 1'b0;
    op    = OP_SLT;
    bsel  = BSEL_RT;
    dest  = rd;
    unique case (opcode)
      OPC_SPECIAL: begin
        if (funct == FN_SLT) begin
          legal = 1'b1;
          op    = OP_SLT;
        end else if (funct == FN_SLTU) begin
          legal = 1'b1;
          op    = OP_SLTU;
        end
      end
      // Immediate forms write rt; SLTIU also sign-extends before the unsigned compare.
      OPC_SLTI: begin
        legal = 1'b1;
        op    = OP_SLTI;
        bsel  = BSEL_IMM;
        dest  = rt;
      end
      OPC_SLTIU: begin
        legal = 1'b1;
        op    = OP_SLTIU;
        bsel  = BSEL_IMM;
        dest  = rt;
      end
      OPC_SPECIAL2: begin
        bsel = BSEL_ZERO;
        if (funct == FN_CLO) begin
          legal = 1'b1;
          op    = OP_CLO;
        end else if (funct == FN_CLZ) begin
          legal = 1'b1;
          op    = OP_CLZ;
        end
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmp_issue_unit.sv
// Sequential initiator for the external ALU comparator: accepts one decoded
// compare instruction, drives the comparator, and hands the result to writeback.
module cmp_issue_unit
  import cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  input  logic [15:0]       in_imm,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rt,
  output logic [DATA_W-1:0] cmp_a,
  output logic [DATA_W-1:0] cmp_b,
  output logic [2:0]        cmp_op,
  input  logic [DATA_W-1:0] cmp_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              err_illegal,
  output logic [15:0]       ops_done
);

  state_e             state_q;
  state_e             state_d;
  cmp_op_e            op_q;
  logic               dec_legal;
  cmp_op_e            dec_op;
  bsel_e              dec_bsel;
  logic [REG_W-1:0]   dec_dest;
  logic [DATA_W-1:0]  b_mux;
  logic [DATA_W-1:0]  exec_result;
  logic               accept;

  cmp_issue_decode #(.REG_W(REG_W)) u_decode (
    .opcode (in_opcode),
    .funct  (in_funct),
    .rd     (in_rd),
    .rt     (in_rt),
    .legal  (dec_legal),
    .op     (dec_op),
    .bsel   (dec_bsel),
    .dest   (dec_dest)
  );

  assign accept = (state_q == IDLE) && in_valid;
  assign cmp_op = op_q;

  always_comb begin
    b_mux = '0;
    unique case (dec_bsel)
      BSEL_RT:   b_mux = in_rt_val;
      BSEL_IMM:  b_mux = {{(DATA_W-16){in_imm[15]}}, in_imm};
      BSEL_ZERO: b_mux = '0;
      default:   b_mux = '0;
    endcase
  end

  assign exec_result = is_full_width(op_q, cmp_a) ? DATA_W'(32) : cmp_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && dec_legal) state_d = EXEC;
      // A zero destination drops the result without visiting writeback.
      EXEC:    state_d = (wb_reg == '0) ? IDLE : WB;
      WB:      if (wb_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == IDLE);
    wb_valid = (state_q == WB);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_a       <= '0;
      cmp_b       <= '0;
      op_q        <= OP_SLT;
      wb_reg      <= '0;
      wb_data     <= '0;
      err_illegal <= 1'b0;
      ops_done    <= '0;
    end else begin
      err_illegal <= accept && !dec_legal;
      if (accept && dec_legal) begin
        cmp_a  <= in_rs_val;
        cmp_b  <= b_mux;
        op_q   <= dec_op;
        wb_reg <= dec_dest;
      end
      if ((state_q == EXEC) && (wb_reg != '0)) wb_data <= exec_result;
      if ((state_q == WB) && wb_ready && (ops_done != 16'hFFFF)) ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_cmp_issue_unit.sv
// Self-checking bench for cmp_issue_unit: directed test-plan steps followed by
// randomized instructions, all checked against an instruction-level model.
module tb_cmp_issue_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_funct;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic [15:0] in_imm;
  logic [4:0]  in_rd;
  logic [4:0]  in_rt;
  logic [31:0] cmp_a;
  logic [31:0] cmp_b;
  logic [2:0]  cmp_op;
  logic [31:0] cmp_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err_illegal;
  logic [15:0] ops_done;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] ops_model  = 16'd0;

  always #5 clk = ~clk;

  cmp_issue_unit #(.DATA_W(32), .REG_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_opcode   (in_opcode),
    .in_funct    (in_funct),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .in_imm      (in_imm),
    .in_rd       (in_rd),
    .in_rt       (in_rt),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .cmp_op      (cmp_op),
    .cmp_result  (cmp_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data),
    .err_illegal (err_illegal),
    .ops_done    (ops_done)
  );

  function automatic logic [31:0] leadCount(input logic [31:0] v, input logic b);
    int n = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] != b) break;
      n++;
    end
    return 32'(n);
  endfunction

  // Stand-in comparator that deliberately answers 0 for the full-width counts.
  function automatic logic [31:0] comparatorModel(input logic [31:0] a, input logic [31:0] b,
                                                  input logic [2:0] op);
    logic [31:0] n;
    case (op)
      3'd0, 3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd1, 3'd3: return {31'b0, a < b};
      3'd4: begin n = leadCount(a, 1'b1); return (n == 32) ? 32'd0 : n; end
      3'd5: begin n = leadCount(a, 1'b0); return (n == 32) ? 32'd0 : n; end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb cmp_result = comparatorModel(cmp_a, cmp_b, cmp_op);

  function automatic void refModel(input logic [5:0] opc, input logic [5:0] fn,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [15:0] imm, input logic [4:0] rd,
                                   input logic [4:0] rti, output logic legal,
                                   output logic [31:0] exp_b, output logic [2:0] exp_op,
                                   output logic [4:0] dest, output logic [31:0] data);
    logic [31:0] simm;
    simm   = {{16{imm[15]}}, imm};
    legal  = 1'b1;
    exp_b  = rt;
    exp_op = 3'd0;
    dest   = rd;
    data   = 32'd0;
    if (opc == 6'h00 && fn == 6'h2A) begin
      exp_op = 3'd0; data = {31'b0, $signed(rs) < $signed(rt)};
    end else if (opc == 6'h00 && fn == 6'h2B) begin
      exp_op = 3'd1; data = {31'b0, rs < rt};
    end else if (opc == 6'h0A) begin
      exp_op = 3'd2; exp_b = simm; dest = rti; data = {31'b0, $signed(rs) < $signed(simm)};
    end else if (opc == 6'h0B) begin
      exp_op = 3'd3; exp_b = simm; dest = rti; data = {31'b0, rs < simm};
    end else if (opc == 6'h1C && fn == 6'h21) begin
      exp_op = 3'd4; exp_b = 32'd0; data = leadCount(rs, 1'b1);
    end else if (opc == 6'h1C && fn == 6'h20) begin
      exp_op = 3'd5; exp_b = 32'd0; data = leadCount(rs, 1'b0);
    end else begin
      legal = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("rst_cmp_a", cmp_a, 32'd0);
    checkOutput("rst_cmp_b", cmp_b, 32'd0);
    checkOutput("rst_cmp_op", {29'b0, cmp_op}, 32'd0);
    checkOutput("rst_wb_reg", {27'b0, wb_reg}, 32'd0);
    checkOutput("rst_wb_data", wb_data, 32'd0);
    checkOutput("rst_err", {31'b0, err_illegal}, 32'd0);
    checkOutput("rst_ops_done", {16'b0, ops_done}, 32'd0);
  endtask

  // Issues one instruction from IDLE (called #1 after an edge) and follows it to completion.
  task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] imm, input logic [4:0] rd,
                               input logic [4:0] rti, input int stall);
    logic        legal;
    logic [31:0] exp_b;
    logic [2:0]  exp_op;
    logic [4:0]  dest;
    logic [31:0] data;
    refModel(opc, fn, rs, rt, imm, rd, rti, legal, exp_b, exp_op, dest, data);
    checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_opcode = opc;
    in_funct  = fn;
    in_rs_val = rs;
    in_rt_val = rt;
    in_imm    = imm;
    in_rd     = rd;
    in_rt     = rti;
    @(posedge clk); #1;
    if (!legal) begin
      in_valid = 1'b0;
      checkOutput("err_pulse", {31'b0, err_illegal}, 32'd1);
      checkOutput("illegal_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
      checkOutput("err_clear", {31'b0, err_illegal}, 32'd0);
      checkOutput("illegal_no_wb", {31'b0, wb_valid}, 32'd0);
      checkOutput("illegal_ops", {16'b0, ops_done}, {16'b0, ops_model});
      return;
    end
    if (stall > 0) in_opcode = 6'h23;
    else           in_valid  = 1'b0;
    checkOutput("exec_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("exec_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("exec_cmp_a", cmp_a, rs);
    checkOutput("exec_cmp_b", cmp_b, exp_b);
    checkOutput("exec_cmp_op", {29'b0, cmp_op}, {29'b0, exp_op});
    @(posedge clk); #1;
    if (dest == 5'd0) begin
      in_valid = 1'b0;
      checkOutput("drop_wb_valid", {31'b0, wb_valid}, 32'd0);
      checkOutput("drop_in_ready", {31'b0, in_ready}, 32'd1);
      checkOutput("drop_ops", {16'b0, ops_done}, {16'b0, ops_model});
      return;
    end
    checkOutput("wb_valid", {31'b0, wb_valid}, 32'd1);
    checkOutput("wb_reg", {27'b0, wb_reg}, {27'b0, dest});
    checkOutput("wb_data", wb_data, data);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checkOutput("stall_wb_valid", {31'b0, wb_valid}, 32'd1);
      checkOutput("stall_wb_reg", {27'b0, wb_reg}, {27'b0, dest});
      checkOutput("stall_wb_data", wb_data, data);
      checkOutput("stall_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("stall_err", {31'b0, err_illegal}, 32'd0);
      checkOutput("stall_ops", {16'b0, ops_done}, {16'b0, ops_model});
    end
    in_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    if (ops_model != 16'hFFFF) ops_model = ops_model + 16'd1;
    checkOutput("post_wb_valid", {31'b0, wb_valid}, 32'd0);
    checkOutput("post_in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("post_ops", {16'b0, ops_done}, {16'b0, ops_model});
  endtask

  initial begin
    logic [5:0]  r_opc;
    logic [5:0]  r_fn;
    logic [31:0] r_rs;
    int          kind;

    reset     = 1'b1;
    in_valid  = 1'b0;
    wb_ready  = 1'b0;
    in_opcode = '0;
    in_funct  = '0;
    in_rs_val = '0;
    in_rt_val = '0;
    in_imm    = '0;
    in_rd     = '0;
    in_rt     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1, 16'h0, 5'd3, 5'd0, 0);
    applyStimulus(6'h0B, 6'h00, 32'd5, 32'd0, 16'hFFFF, 5'd0, 5'd7, 0);
    applyStimulus(6'h0A, 6'h00, 32'd5, 32'd0, 16'hFFFF, 5'd0, 5'd7, 0);
    applyStimulus(6'h1C, 6'h20, 32'd0, 32'd9, 16'h0, 5'd4, 5'd0, 0);
    applyStimulus(6'h1C, 6'h21, 32'hFFFF_FFFF, 32'd9, 16'h0, 5'd5, 5'd0, 0);
    applyStimulus(6'h1C, 6'h21, 32'hF000_0000, 32'd9, 16'h0, 5'd6, 5'd0, 0);
    applyStimulus(6'h00, 6'h2B, 32'd1, 32'hFFFF_FFFF, 16'h0, 5'd8, 5'd0, 5);

    wb_ready = 1'b1;
    applyStimulus(6'h23, 6'h00, 32'd1, 32'd2, 16'h4, 5'd9, 5'd9, 0);
    wb_ready = 1'b0;

    in_valid  = 1'b1;
    in_opcode = 6'h23;
    @(posedge clk); #1;
    checkOutput("b2b_err_first", {31'b0, err_illegal}, 32'd1);
    in_opcode = 6'h3F;
    @(posedge clk); #1;
    checkOutput("b2b_err_second", {31'b0, err_illegal}, 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b_err_clear", {31'b0, err_illegal}, 32'd0);

    applyStimulus(6'h00, 6'h2A, 32'd1, 32'd2, 16'h0, 5'd0, 5'd0, 0);

    in_valid  = 1'b1;
    in_opcode = 6'h00;
    in_funct  = 6'h2A;
    in_rs_val = 32'h8000_0000;
    in_rt_val = 32'd1;
    in_rd     = 5'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("pre_rst_exec", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    #1;
    ops_model = 16'd0;
    checkReset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_lost_wb", {31'b0, wb_valid}, 32'd0);
    applyStimulus(6'h00, 6'h2A, 32'h8000_0000, 32'd1, 16'h0, 5'd12, 5'd0, 0);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 6);
      r_fn = 6'($urandom);
      r_opc = 6'($urandom);
      case (kind)
        0: begin r_opc = 6'h00; r_fn = 6'h2A; end
        1: begin r_opc = 6'h00; r_fn = 6'h2B; end
        2: r_opc = 6'h0A;
        3: r_opc = 6'h0B;
        4: begin r_opc = 6'h1C; r_fn = 6'h21; end
        5: begin r_opc = 6'h1C; r_fn = 6'h20; end
        default: if (r_opc == 6'h0A || r_opc == 6'h0B) r_opc = 6'h2F;
      endcase
      case ($urandom_range(0, 3))
        0:       r_rs = 32'hFFFF_FFFF;
        1:       r_rs = 32'd0;
        default: r_rs = $urandom >> $urandom_range(0, 31);
      endcase
      applyStimulus(r_opc, r_fn, r_rs, $urandom, 16'($urandom),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cmp_issue_unit.md
# cmp_issue_unit

Sequential initiator for the ALU comparator (SLT/SLTU/SLTI/SLTIU/CLO/CLZ responder).
- Accepts one decoded MIPS compare-class instruction at a time over a valid/ready handshake.
- Forms the comparator operands and op code, samples the comparator result and presents it to register-file writeback over a second valid/ready handshake.
- Sits between the decode stage and the writeback port; the comparator itself is instantiated outside this block.

## Interface
Parameters:
- DATA_W, 32, operand/result width (only 32 is supported)
- REG_W, 5, register index width

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept; high only in IDLE
- in_opcode  in  6  MIPS opcode field
- in_funct  in  6  MIPS funct field
- in_rs_val  in  DATA_W  rs register value
- in_rt_val  in  DATA_W  rt register value
- in_imm  in  16  immediate field
- in_rd  in  REG_W  rd index
- in_rt  in  REG_W  rt index
- cmp_a  out  DATA_W  comparator operand A (registered)
- cmp_b  out  DATA_W  comparator operand B (registered)
- cmp_op  out  3  comparator op: 0 SLT, 1 SLTU, 2 SLTI, 3 SLTIU, 4 CLO, 5 CLZ
- cmp_result  in  DATA_W  comparator result (combinational from cmp_a/cmp_b/cmp_op)
- wb_valid  out  1  writeback data valid
- wb_ready  in  1  writeback accepted
- wb_reg  out  REG_W  destination register
- wb_data  out  DATA_W  result
- err_illegal  out  1  one-cycle pulse for an unsupported instruction
- ops_done  out  16  saturating count of completed writebacks

## Operation
- Decode:
  - opcode 0x00, funct 0x2A → SLT
  - opcode 0x00, funct 0x2B → SLTU
  - opcode 0x0A → SLTI
  - opcode 0x0B → SLTIU
  - opcode 0x1C, funct 0x21 → CLO
  - opcode 0x1C, funct 0x20 → CLZ
  - anything else is illegal.
- Operands:
  - R-type: cmp_a = rs_val, cmp_b = rt_val, dest = rd.
  - I-type: cmp_a = rs_val, cmp_b = sign-extended imm, dest = rt. This applies to SLTIU as well.
  - CLO/CLZ: cmp_a = rs_val, cmp_b = 0, dest = rd.
- States: IDLE, EXEC, WB.
  - IDLE: in_ready = 1. On in_valid, a legal instruction latches operands, op and dest, then goes to EXEC. An illegal instruction is still consumed, pulses err_illegal the next cycle and stays in IDLE.
  - EXEC: one cycle with operands stable. At the end of the cycle, cmp_result is registered into wb_data, subject to the override rule below.
    - dest = 0: the result is dropped, ops_done is unchanged, next state IDLE.
    - Otherwise: next state WB.
  - WB: wb_valid = 1. wb_reg/wb_data are held stable until wb_ready. On the wb_valid && wb_ready edge, ops_done increments (saturating at 0xFFFF) and the state returns to IDLE.
- Override rule: the block does not trust the comparator for the full-width cases.
  - CLO with rs_val = 0xFFFFFFFF → wb_data = 32.
  - CLZ with rs_val = 0 → wb_data = 32.
  - All other results come from cmp_result.

## Timing
- Reset values: state IDLE, in_ready 1, cmp_a/cmp_b/wb_data 0, cmp_op 0, wb_reg 0, wb_valid 0, err_illegal 0, ops_done 0.
- Latency: an accept on edge N gives EXEC during cycle N+1 and wb_valid high from edge N+2.
- Throughput: at most one instruction per 3 cycles (no overlap).
- in_ready is low in EXEC and WB. in_valid in those states is ignored, not queued.
- Backpressure: wb_valid stays high indefinitely while wb_ready = 0. No output changes while stalled.
- wb_ready high outside WB has no effect.
- Reset asserted mid-EXEC or mid-WB:
  - returns immediately to IDLE with all outputs at reset values;
  - the in-flight instruction is lost and no writeback occurs.
- err_illegal is asserted for exactly one cycle per illegal accept. Back-to-back illegal instructions give consecutive pulses.

## Structure
- Package cmp_pkg holds:
  - opcode/funct constants;
  - cmp_op encodings 0–5;
  - state enum {IDLE, EXEC, WB}.
- Sub-module cmp_issue_decode: purely combinational decode from opcode/funct/fields to {legal, cmp_op, operand B select, dest}.
- FSM, registers, override logic and counter live in cmp_issue_unit.

## Test plan
- SLT with rs = 0xFFFFFFFF (−1), rt = 1, rd = 3 → wb_reg 3, wb_data 1, wb_valid exactly 2 cycles after accept.
- SLTIU with rs = 5, imm = 0xFFFF → cmp_b = 0xFFFFFFFF, wb_data 1 (rt dest). SLTI with the same inputs → wb_data 0.
- CLZ with rs = 0 → 32. CLO with rs = 0xFFFFFFFF → 32. CLO with rs = 0xF0000000 → 4.
- wb_ready held low for 5 cycles in WB → wb_valid/wb_reg/wb_data stable and in_ready 0. Then accept → IDLE, ops_done +1.
- opcode 0x23 (LW) offered → err_illegal pulses once, no wb_valid. SLT with rd = 0 → no wb_valid, ops_done unchanged.
- reset asserted during EXEC → outputs at reset values next sample. A new SLT afterwards completes normally.
